// File: rtl/bus_ctrl_if.sv
// Bus controller interface: CPU data port on one side, memory-mapped slaves on the other.
// The master modport is the controller's view; the slave modport is the environment
// (CPU plus slaves) seen from outside the controller.
interface bus_ctrl_if #(
    parameter int NUM_SLAVES = 5
);
    // CPU side
    logic                       cpu_req;
    logic [31:0]                cpu_addr;
    logic [31:0]                cpu_wdata;
    logic                       cpu_wen;
    logic [1:0]                 cpu_size;
    logic                       cpu_ready;
    logic [31:0]                cpu_rdata;
    logic                       cpu_err;
    // Slave side
    logic [NUM_SLAVES-1:0]      s_req;
    logic                       s_wen;
    logic [31:0]                s_addr;
    logic [31:0]                s_wdata;
    logic [3:0]                 s_wstrb;
    logic [NUM_SLAVES-1:0]      s_ready;
    logic [NUM_SLAVES*32-1:0]   s_rdata;

    modport master (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wen, cpu_size, s_ready, s_rdata,
        output cpu_ready, cpu_rdata, cpu_err, s_req, s_wen, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wen, cpu_size, s_ready, s_rdata,
        input  cpu_ready, cpu_rdata, cpu_err, s_req, s_wen, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/bus_ctrl_fsm.sv
// Registered multi-cycle bus controller: decodes the CPU request onto one of
// NUM_SLAVES targets by addr[31:28] tag, generates byte strobes, checks alignment,
// times out silent slaves and returns an error response for bad accesses.
module bus_ctrl_fsm #(
    parameter int                      NUM_SLAVES = 5,
    parameter logic [NUM_SLAVES*4-1:0] SLAVE_TAGS = {4'hc, 4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                      TIMEOUT    = 15,
    parameter logic [31:0]             ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_ctrl_if.master  bus,
    output logic [15:0] err_count,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [NUM_SLAVES-1:0] sel_dec;
    logic                  hit;
    logic                  misaligned;
    logic [3:0]            wstrb_dec;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  timeout_hit;

    // Decode the incoming request: lowest matching tag, alignment and strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel_dec    = '0;
        hit        = 1'b0;
        misaligned = 1'b0;
        wstrb_dec  = 4'b0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && SLAVE_TAGS[i*4 +: 4] == bus.cpu_addr[31:28]) begin
                sel_dec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
        case (bus.cpu_size)
            2'd0: wstrb_dec = 4'b0001 << bus.cpu_addr[1:0];
            2'd1: begin
                wstrb_dec  = 4'b0011 << {bus.cpu_addr[1], 1'b0};
                misaligned = bus.cpu_addr[0];
            end
            2'd2: begin
                wstrb_dec  = 4'b1111;
                misaligned = (bus.cpu_addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Pick the ready flag and read data of the currently selected slave only.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | bus.s_rdata[i*32 +: 32];
        end
    end

    assign sel_ready   = |(bus.s_ready & sel_q);
    // Counter holds completed wait cycles; this cycle is the TIMEOUT-th one.
    assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == TIMEOUT_L;

    // Next-state and datapath update for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    wen_d   = bus.cpu_wen;
                    wstrb_d = wstrb_dec;
                    if (misaligned || !hit) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        sel_d   = sel_dec;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = wen_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    sel_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (err_q && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, including an access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.cpu_ready = (state_q == RESP);
    assign bus.cpu_err   = (state_q == RESP) && err_q;
    assign bus.cpu_rdata = (state_q != RESP) ? 32'h0 : (err_q ? ERR_RDATA : rdata_q);
    assign bus.s_req     = sel_q;
    assign bus.s_wen     = wen_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_wstrb   = wstrb_q;
    assign err_count     = err_count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
// Self-checking bench for bus_ctrl_fsm: directed boundary cases plus random accesses
// compared against a transaction-level expectation (latency, response, strobes).
module tb_bus_ctrl_fsm;
    localparam int          NS   = 5;
    localparam int          TO   = 15;
    localparam logic [19:0] TAGS = {4'hc, 4'h3, 4'h2, 4'h1, 4'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_ctrl_if #(.NUM_SLAVES(NS)) bif();
    logic [15:0] err_count;
    logic        busy;

    bus_ctrl_fsm #(.NUM_SLAVES(NS), .SLAVE_TAGS(TAGS), .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .err_count(err_count), .busy(busy)
    );

    // Second instance with duplicate tags and zero-wait slaves.
    bus_ctrl_if #(.NUM_SLAVES(2)) dif();
    logic [15:0] d_err_count;
    logic        d_busy;

    bus_ctrl_fsm #(.NUM_SLAVES(2), .SLAVE_TAGS(8'h11), .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) u_dup (
        .clk(clk), .rst_n(rst_n), .bus(dif), .err_count(d_err_count), .busy(d_busy)
    );

    assign dif.s_ready = dif.s_req;
    assign dif.s_rdata = {32'h2222_2222, 32'h1111_1111};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave model state
    int          slave_delay = -1;
    int          scnt = 0;
    bit          req_prev = 0;
    logic [31:0] sdata [NS];
    int          model_errs = 0;

    // One clock: advance past the edge, then let the slave model respond to s_req.
    task automatic step();
        logic [NS-1:0] rdy;
        @(posedge clk);
        #1;
        if (|bif.s_req) begin
            if (!req_prev) scnt = 0;
            else scnt++;
        end
        req_prev = |bif.s_req;
        rdy = NS'($urandom) & ~bif.s_req;
        if (|bif.s_req && scnt == slave_delay) rdy = rdy | bif.s_req;
        bif.s_ready = rdy;
    endtask

    task automatic run_access(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                              input logic [31:0] wdata, input int delay);
        logic [19:0]   tags_v;
        int            idx;
        bit            mis, errp, tmo, exp_err, seen, bad_sreq;
        int            lat, exp_sreq, cyc, sreq_cycles;
        logic [31:0]   exp_rdata, got_rdata;
        logic          got_err;
        logic [3:0]    exp_strb;
        logic [NS-1:0] exp_onehot;

        tags_v = TAGS;
        idx = -1;
        for (int i = 0; i < NS; i++)
            if (idx < 0 && tags_v[i*4 +: 4] == addr[31:28]) idx = i;
        mis  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        errp = mis || (idx < 0);
        tmo  = !errp && (delay < 0 || delay >= TO);
        for (int i = 0; i < NS; i++) begin
            sdata[i] = $urandom;
            bif.s_rdata[i*32 +: 32] = sdata[i];
        end
        slave_delay = delay;
        exp_onehot = '0;
        if (errp) begin
            lat = 1; exp_sreq = 0; exp_rdata = 32'hDEAD_BEEF; exp_err = 1;
        end else if (tmo) begin
            lat = TO + 1; exp_sreq = TO; exp_rdata = 32'hDEAD_BEEF; exp_err = 1;
            exp_onehot[idx] = 1'b1;
        end else begin
            lat = delay + 2; exp_sreq = delay + 1; exp_rdata = wen ? 32'h0 : sdata[idx]; exp_err = 0;
            exp_onehot[idx] = 1'b1;
        end
        case (size)
            2'd0:    exp_strb = 4'b0001 << addr[1:0];
            2'd1:    exp_strb = addr[1] ? 4'b1100 : 4'b0011;
            default: exp_strb = 4'b1111;
        endcase

        bif.cpu_req   = 1'b1;
        bif.cpu_addr  = addr;
        bif.cpu_size  = size;
        bif.cpu_wen   = wen;
        bif.cpu_wdata = wdata;

        cyc = 0; seen = 0; sreq_cycles = 0; bad_sreq = 0;
        got_rdata = '0; got_err = 1'b0;
        while (!seen && cyc < 60) begin
            step();
            cyc++;
            if (cyc == 1) begin
                check("s_addr", bif.s_addr, addr);
                check("s_wdata", bif.s_wdata, wdata);
                check("s_wen", bif.s_wen, wen);
                check("busy_run", busy, 1);
                if (size != 2'd3) check("s_wstrb", bif.s_wstrb, exp_strb);
            end
            if (|bif.s_req) begin
                sreq_cycles++;
                if (bif.s_req !== exp_onehot) bad_sreq = 1;
            end
            if (bif.cpu_ready === 1'b1) begin
                seen = 1;
                got_rdata = bif.cpu_rdata;
                got_err = bif.cpu_err;
            end
        end
        if (exp_err && model_errs < 65535) model_errs++;
        check("ready_seen", seen, 1);
        check("latency", cyc, lat);
        check("cpu_err", got_err, exp_err);
        check("cpu_rdata", got_rdata, exp_rdata);
        check("s_req_cycles", sreq_cycles, exp_sreq);
        check("s_req_onehot", bad_sreq, 0);

        bif.cpu_req = 1'b0;
        step();
        check("ready_one_cycle", bif.cpu_ready, 0);
        check("busy_idle", busy, 0);
        check("err_count", err_count, model_errs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  tag_pool [7];
        logic [31:0] a;
        logic [1:0]  sz;
        int          dly, q_first, q_second, q_third, n_rdy;
        bit          flag;

        tag_pool = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hc, 4'h5, 4'hf};
        bif.cpu_req = 0; bif.cpu_addr = '0; bif.cpu_wdata = '0; bif.cpu_wen = 0; bif.cpu_size = '0;
        bif.s_ready = '0; bif.s_rdata = '0;
        dif.cpu_req = 0; dif.cpu_addr = '0; dif.cpu_wdata = '0; dif.cpu_wen = 0; dif.cpu_size = '0;

        // Reset values
        #12;
        check("rst_cpu_ready", bif.cpu_ready, 0);
        check("rst_cpu_rdata", bif.cpu_rdata, 0);
        check("rst_cpu_err", bif.cpu_err, 0);
        check("rst_s_req", bif.s_req, 0);
        check("rst_s_bus", {bif.s_wen, bif.s_addr, bif.s_wdata, bif.s_wstrb}, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset in the middle of ACCESS
        slave_delay = -1;
        bif.cpu_req = 1; bif.cpu_addr = 32'h2000_0000; bif.cpu_size = 2'd2; bif.cpu_wen = 0;
        step();
        step();
        check("mid_s_req", bif.s_req, 5'b00100);
        #2 rst_n = 1'b0;
        #1;
        check("async_s_req", bif.s_req, 0);
        check("async_busy", busy, 0);
        step();
        bif.cpu_req = 0;
        rst_n = 1'b1;
        flag = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bif.cpu_ready !== 1'b0) flag = 1;
        end
        check("no_resp_after_rst", flag, 0);
        check("err_count_after_rst", err_count, 0);

        // Directed accesses
        run_access(32'h1000_0010, 2'd2, 1'b0, 32'h0, 0);
        run_access(32'hC000_0003, 2'd0, 1'b1, 32'hAB00_0000, 1);
        run_access(32'h2000_0002, 2'd1, 1'b1, 32'h5A5A_0000, 0);
        run_access(32'h1000_0001, 2'd1, 1'b0, 32'h0, 0);
        run_access(32'h5000_0000, 2'd2, 1'b0, 32'h0, 0);
        run_access(32'h0000_0000, 2'd3, 1'b0, 32'h0, 0);
        check("err_count_three", err_count, 3);
        run_access(32'h2000_0000, 2'd2, 1'b0, 32'h0, -1);
        run_access(32'h2000_0004, 2'd2, 1'b0, 32'h0, TO - 1);
        run_access(32'h3000_0008, 2'd2, 1'b0, 32'h0, TO);

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            a  = {tag_pool[$urandom_range(0, 6)], 28'($urandom)};
            sz = 2'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 16));
            run_access(a, sz, 1'($urandom), $urandom, dly);
        end

        // Duplicate tags, request held through cpu_ready: back-to-back accesses
        dif.cpu_addr = 32'h1ABC_0000; dif.cpu_size = 2'd2; dif.cpu_wen = 0; dif.cpu_req = 1;
        flag = 0; n_rdy = 0; q_first = 0; q_second = 0; q_third = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (dif.s_req !== 2'b00 && dif.s_req !== 2'b01) flag = 1;
            if (dif.cpu_ready === 1'b1) begin
                n_rdy++;
                if (n_rdy == 1) q_first = c;
                if (n_rdy == 2) q_second = c;
                if (n_rdy == 3) q_third = c;
                check("dup_rdata", dif.cpu_rdata, 32'h1111_1111);
                check("dup_err", dif.cpu_err, 0);
            end
        end
        dif.cpu_req = 0;
        check("dup_only_slave0", flag, 0);
        check("dup_first_latency", q_first, 2);
        check("dup_spacing_1", q_second - q_first, 3);
        check("dup_spacing_2", q_third - q_second, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_ctrl_fsm.md
# bus_ctrl_fsm

Registered, multi-cycle successor to the combinational memory-mapped bus decoder. It sits between the CPU data port and NUM_SLAVES memory-mapped targets (ROM, RAM, VRAM, palette, device IO, ...). Each slave is selected by a parametrised 4-bit tag on addr[31:28]. The block adds:
- a request/ready handshake with variable-latency slaves,
- byte-strobe generation,
- alignment checks,
- a per-access timeout,
- an error response for unmapped, misaligned or timed-out accesses.

## Interface
Parameters:
- NUM_SLAVES, 5, number of slave ports (1..16)
- SLAVE_TAGS, {4'hc,4'h3,4'h2,4'h1,4'h0}, NUM_SLAVES*4 bits; slice i is the addr[31:28] tag of slave i
- TIMEOUT, 15, maximum ACCESS cycles waiting for s_ready (1..255)
- ERR_RDATA, 32'hDEAD_BEEF, cpu_rdata value on any error response

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cpu_req  in  1  access request; held with stable addr/wdata/wen/size until cpu_ready
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  lane-aligned write data
- cpu_wen  in  1  1 = write, 0 = read
- cpu_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- cpu_ready  out  1  one-cycle response strobe
- cpu_rdata  out  32  read data, valid while cpu_ready is high
- cpu_err  out  1  error flag, valid while cpu_ready is high
- s_req  out  NUM_SLAVES  one-hot slave select, held for the whole access
- s_wen  out  1  latched write enable
- s_addr  out  32  latched address
- s_wdata  out  32  latched write data
- s_wstrb  out  4  byte strobes
- s_ready  in  NUM_SLAVES  slave completion, sampled only for the selected slave
- s_rdata  in  NUM_SLAVES*32  slave read data; slice i belongs to slave i
- err_count  out  16  saturating count of error responses
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**, cpu_req=1: latch addr, wdata, wen and size, then decode.
  - Slave match: lowest index i with SLAVE_TAGS[i] == addr[31:28]. Duplicate tags resolve to the lowest index.
  - Alignment error when any of these hold: size=3; size=1 with addr[0]=1; size=2 with addr[1:0]≠0.
  - Misaligned or unmapped: go to RESP with error; no slave is selected.
  - Otherwise: go to ACCESS, set s_req[i], clear the timeout counter.
- **s_wstrb** (registered with the latch):
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - Strobes are also driven on reads; slaves ignore them.
- **ACCESS**, each cycle:
  - s_ready[i]=1: capture s_rdata slice i (reads) or 0 (writes) into the response register, drop s_req, go to RESP with no error.
  - Otherwise the counter increments. When it reaches TIMEOUT with s_ready still low: drop s_req, go to RESP with error.
  - s_ready on unselected slaves is ignored.
- **RESP**: cpu_ready=1 for exactly one cycle; cpu_rdata is the response register, or ERR_RDATA when cpu_err=1. Next state is always IDLE.
  - cpu_req is ignored in ACCESS and RESP.
  - A request held through the cpu_ready cycle is treated as a new access in the following IDLE cycle.
- **err_count** increments in each RESP cycle with cpu_err=1 and saturates at 16'hFFFF.
- s_addr, s_wdata, s_wen and s_wstrb hold their latched values until the next IDLE accept.

## Timing
- Reset values: all outputs 0; FSM in IDLE; err_count 0; counter 0; response register 0.
- Assertion of rst_n=0 clears everything immediately, mid-access included: s_req drops asynchronously and the pending response is discarded.
- Request accepted at edge T:
  - s_req is high during cycle T+1.
  - A slave ready combinationally in T+1 gives cpu_ready in T+2. Minimum latency is 2 cycles.
  - A slave asserting s_ready k cycles after s_req gives cpu_ready in T+2+k.
- Unmapped or misaligned request: cpu_ready and cpu_err in T+1. s_req is never asserted.
- Timeout: s_req is high for exactly TIMEOUT cycles, then cpu_ready with cpu_err in the next cycle.
- s_ready arriving in the same cycle the counter hits TIMEOUT: ready wins, no error.
- Back-to-back throughput: one access per 3 cycles with zero-wait slaves (IDLE, ACCESS, RESP).

## Test plan
- Reset values: hold rst_n=0 → all outputs 0. Release it, then assert rst_n=0 in the middle of ACCESS → s_req falls the same cycle and there is no cpu_ready afterwards.
- Word read, 0x1000_0010, slave 1 ready immediately with s_rdata 0x1234_5678 → s_req=5'b00010 for 1 cycle; cpu_ready in T+2 with rdata 0x1234_5678, err=0.
- Byte write, addr 0xC000_0003, wdata 0xAB00_0000 → s_req[4]=1, s_wstrb=4'b1000, s_wen=1. Half write at 0x2000_0002 → s_wstrb=4'b1100.
- Half read at 0x1000_0001, read at 0x5000_0000 (unmapped), and size=3 access → each gives cpu_ready in T+1 with err=1 and rdata 0xDEAD_BEEF, no s_req; err_count reaches 3.
- Slave 2 never ready, TIMEOUT=15 → s_req[2] high for 15 cycles, then err=1 and rdata 0xDEAD_BEEF. Repeat with s_ready arriving on the 15th cycle → err=0.
- Duplicate tags {4'h1,4'h1} at slices 0 and 1, access 0x1xxx_xxxx → only s_req[0] asserted. Hold cpu_req through cpu_ready → second access accepted in the next cycle, 3-cycle spacing.
